hash_target_check: RTL and testbench

Word-serial comparator that sits directly downstream of the compact-target expander in the mining datapath. It takes each finished double-SHA-256 digest with its nonce, and compares the digest against the expanded 256-bit target one 32-bit word per cycle, most significant word first, exiting as soon as the result is decided. It returns a pass/fail result with the nonce through a valid/ready handshake, and keeps running statistics for the host interface.

---
 rtl/mining_pkg.sv | 26 ++
 rtl/word_cmp32.sv | 20 ++
 rtl/hash_target_check.sv | 127 ++++++++++++
 tb/tb_hash_target_check.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mining_pkg
// Description : Shared constants, FSM state type and word-select helper for
//               the mining datapath.
// Revision    : 1.0  initial release
// ============================================================================
package mining_pkg;

    localparam int HASH_WORDS = 8;
    localparam int IDX_W      = $clog2(HASH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word idx occupies bits 32*idx+31 : 32*idx of the 256-bit value.
    function automatic logic [31:0] word_sel(input logic [255:0] vec256,
                                             input logic [IDX_W-1:0] idx);
        return vec256[{idx, 5'b00000} +: 32];
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_cmp32.sv
`default_nettype none
// ============================================================================
// Module      : word_cmp32
// Description : Combinational three-way unsigned compare of two 32-bit words.
// Revision    : 1.0  initial release
// ============================================================================
module word_cmp32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt,
    output logic        eq,
    output logic        gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule
`default_nettype wire

// File: rtl/hash_target_check.sv
`default_nettype none
// ============================================================================
// Module      : hash_target_check
// Description : Word-serial digest-vs-target comparator (MS word first, early
//               exit) with valid/ready result handshake and statistics.
// Revision    : 1.0  initial release
// ============================================================================
module hash_target_check
    import mining_pkg::*;
#(
    parameter int NONCE_W = 32,
    parameter int HIT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [255:0]       target_in,
    input  logic               hash_valid,
    output logic               hash_ready,
    input  logic [255:0]       hash_in,
    input  logic [NONCE_W-1:0] nonce_in,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               result_meet,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [31:0]        hashes_checked,
    output logic [HIT_W-1:0]   hits
);

    localparam logic [IDX_W-1:0] c_top_idx = IDX_W'(HASH_WORDS - 1);
    localparam logic [HIT_W-1:0] c_hit_max = {HIT_W{1'b1}};

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [255:0]       r_hash;
    logic [255:0]       r_target;
    logic [NONCE_W-1:0] r_nonce;
    logic               r_meet;
    logic               r_valid;
    logic               r_hash_ready;
    logic [31:0]        r_hashes_checked;
    logic [HIT_W-1:0]   r_hits;

    logic [31:0] w_h_word;
    logic [31:0] w_t_word;
    logic        w_lt;
    logic        w_eq;
    logic        w_gt;

    assign w_h_word = word_sel(r_hash, r_idx);
    assign w_t_word = word_sel(r_target, r_idx);

    word_cmp32 u_word_cmp (
        .a  (w_h_word),
        .b  (w_t_word),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_idx            <= c_top_idx;
            r_hash           <= '0;
            r_target         <= '0;
            r_nonce          <= '0;
            r_meet           <= 1'b0;
            r_valid          <= 1'b0;
            r_hash_ready     <= 1'b0;
            r_hashes_checked <= '0;
            r_hits           <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (hash_valid && r_hash_ready) begin
                        // Target is snapshotted here so later expander updates
                        // cannot disturb the compare in flight.
                        r_hash           <= hash_in;
                        r_target         <= target_in;
                        r_nonce          <= nonce_in;
                        r_idx            <= c_top_idx;
                        r_hashes_checked <= r_hashes_checked + 32'd1;
                        r_hash_ready     <= 1'b0;
                        r_state          <= CMP;
                    end else begin
                        r_hash_ready     <= 1'b1;
                    end
                end
                CMP: begin
                    if (w_lt || (w_eq && (r_idx == '0))) begin
                        r_meet  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (w_gt) begin
                        r_meet  <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_valid      <= 1'b0;
                        r_hash_ready <= 1'b1;
                        r_state      <= IDLE;
                        if (r_meet && (r_hits != c_hit_max)) begin
                            r_hits <= r_hits + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign hash_ready     = r_hash_ready;
    assign result_valid   = r_valid;
    assign result_meet    = r_meet;
    assign result_nonce   = r_nonce;
    assign hashes_checked = r_hashes_checked;
    assign hits           = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_hash_target_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_target_check
// Description : Directed, table-driven self-checking bench for
//               hash_target_check.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hash_target_check;

    localparam int HIT_W = 4;
    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

    logic               clk = 1'b0;
    logic               rst;
    logic [255:0]       target_in;
    logic               hash_valid;
    logic               hash_ready;
    logic [255:0]       hash_in;
    logic [31:0]        nonce_in;
    logic               result_valid;
    logic               result_ready;
    logic               result_meet;
    logic [31:0]        result_nonce;
    logic [31:0]        hashes_checked;
    logic [HIT_W-1:0]   hits;

    hash_target_check #(
        .NONCE_W (32),
        .HIT_W   (HIT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .target_in      (target_in),
        .hash_valid     (hash_valid),
        .hash_ready     (hash_ready),
        .hash_in        (hash_in),
        .nonce_in       (nonce_in),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_meet    (result_meet),
        .result_nonce   (result_nonce),
        .hashes_checked (hashes_checked),
        .hits           (hits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] hash;
        logic [255:0] target;
        logic [31:0]  nonce;
        logic         meet;
        int           lat;
    } vec_t;

    int               pass_cnt = 0;
    int               total_cnt = 0;
    logic [31:0]      exp_checked;
    logic [HIT_W-1:0] exp_hits;
    vec_t             vecs[8];

    // Expansion of compact target 0x1d00ffff.
    localparam logic [255:0] T0 = {32'h0, 32'hFFFF_0000, 192'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic send(input logic [255:0] h, input logic [255:0] t, input logic [31:0] n,
                        input logic meet, input int lat, input int hold);
        int  c;
        int  w;
        bit  seen;
        w = 0;
        while (!hash_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", hash_ready, 1);
        hash_in    = h;
        target_in  = t;
        nonce_in   = n;
        hash_valid = 1'b1;
        @(posedge clk);
        #1;
        hash_valid  = 1'b0;
        hash_in     = '0;
        target_in   = ~t;
        exp_checked = exp_checked + 32'd1;
        c = 0;
        seen = 0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            if (result_valid) seen = 1;
            else chk("busy_ready", hash_ready, 0);
        end
        chk("valid_seen", seen, 1);
        chk("latency", c, lat);
        chk("meet", result_meet, meet);
        chk("nonce", result_nonce, n);
        chk("checked", hashes_checked, exp_checked);
        // Backpressure: offer another digest that must not be taken.
        for (int i = 0; i < hold; i++) begin
            hash_valid = 1'b1;
            hash_in    = ~h;
            target_in  = t ^ {8{32'h5A5A_A5A5}};
            @(negedge clk);
            chk("hold_valid", result_valid, 1);
            chk("hold_meet", result_meet, meet);
            chk("hold_nonce", result_nonce, n);
            chk("hold_ready", hash_ready, 0);
        end
        hash_valid   = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        if (meet && exp_hits != HIT_MAX) exp_hits = exp_hits + 1'b1;
        @(negedge clk);
        chk("ready_after", hash_ready, 1);
        chk("valid_after", result_valid, 0);
        chk("hits", hits, exp_hits);
        chk("checked_after", hashes_checked, exp_checked);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw;
        vecs[0] = '{{32'h0, 32'h0000_ABCD, 192'h0}, T0, 32'h1234_5678, 1'b1, 3};
        vecs[1] = '{{32'h1, 224'h0}, T0, 32'hDEAD_0001, 1'b0, 2};
        vecs[2] = '{T0, T0, 32'hDEAD_0002, 1'b1, 9};
        vecs[3] = '{T0 | 256'h1, T0, 32'hDEAD_0003, 1'b0, 9};
        vecs[4] = '{{{4{32'h8000_0000}}, 32'h7FFF_FFFF, 96'h0}, {8{32'h8000_0000}},
                    32'hDEAD_0004, 1'b1, 6};
        vecs[5] = '{{{7{32'h1234_5678}}, 32'h1234_5677}, {8{32'h1234_5678}},
                    32'hDEAD_0005, 1'b1, 9};
        vecs[6] = '{{8{32'hFFFF_FFFF}}, T0, 32'hDEAD_0006, 1'b0, 2};
        vecs[7] = '{256'h0, 256'h0, 32'hDEAD_0007, 1'b1, 9};

        rst          = 1'b1;
        hash_valid   = 1'b0;
        result_ready = 1'b0;
        hash_in      = '0;
        target_in    = '0;
        nonce_in     = '0;
        exp_checked  = '0;
        exp_hits     = '0;
        repeat (3) @(negedge clk);
        chk("rst_hash_ready", hash_ready, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_meet", result_meet, 0);
        chk("rst_nonce", result_nonce, 0);
        chk("rst_checked", hashes_checked, 0);
        chk("rst_hits", hits, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", hash_ready, 1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].hash, vecs[i].target, vecs[i].nonce, vecs[i].meet, vecs[i].lat, 0);
        end

        // Long backpressure with target churn during the compare.
        send(vecs[0].hash, vecs[0].target, 32'hCAFE_0000, 1'b1, 3, 20);
        send(vecs[3].hash, vecs[3].target, 32'hCAFE_0001, 1'b0, 9, 20);

        // Reset in cycle T+4 of a full-length compare.
        hash_in    = T0;
        target_in  = T0;
        nonce_in   = 32'hBAD0_0000;
        hash_valid = 1'b1;
        @(posedge clk);
        #1;
        hash_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_ready", hash_ready, 0);
        chk("midrst_checked", hashes_checked, 0);
        chk("midrst_hits", hits, 0);
        rst = 1'b0;
        exp_checked = '0;
        exp_hits    = '0;
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (result_valid) saw = 1;
        end
        chk("midrst_no_result", saw, 0);
        chk("midrst_ready_after", hash_ready, 1);
        send(vecs[5].hash, vecs[5].target, 32'hBEEF_0001, 1'b1, 9, 0);

        // Drive hits into saturation and past it.
        for (int i = 0; i < 17; i++) begin
            send(vecs[0].hash, vecs[0].target, 32'h5A00_0000 + i, 1'b1, 3, 0);
        end
        chk("hits_saturated", hits, HIT_MAX);
        send(vecs[1].hash, vecs[1].target, 32'h5A00_00FF, 1'b0, 2, 0);

        // Preload the digest counter to its maximum and watch it wrap.
        force dut.r_hashes_checked = 32'hFFFF_FFFF;
        #1;
        release dut.r_hashes_checked;
        exp_checked = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("checked_preload", hashes_checked, exp_checked);
        send(vecs[0].hash, vecs[0].target, 32'h0000_0F0F, 1'b1, 3, 0);
        chk("checked_wrapped", hashes_checked, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
